fir_interp2_folded: RTL and testbench

Two-times polyphase interpolating FIR. It runs sample-rate expansion on the transmit side of the filter chain and is the counterpart of the decimating/receive-side symmetric FIR. It accepts one Q8.8 sample per input handshake and emits two output samples per input: an even phase and an odd phase. The block uses the team's 11-tap symmetric Q8.8 prototype and a single time-multiplexed MAC.

---
 rtl/fir_interp2_folded.sv | 210 +++++++++++++++++++++
 tb/tb_fir_interp2_folded.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp2_folded.sv
// ---------------------------------------------------------------------------
// fir_interp2_folded
//
// Two-times polyphase interpolating FIR for the transmit side of the filter
// chain. Each accepted input sample produces two output samples. The even
// phase uses the even-indexed taps of the 11-tap symmetric Q8.8 prototype.
// The odd phase uses the odd-indexed taps. A single multiply-accumulate
// unit is time-shared across both phases, so one sample takes 16 cycles when
// the downstream never stalls.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (release synchronous to clk)
//   data_in    signed input sample
//   in_valid   data_in is valid
//   in_ready   block can take a sample (only while idle)
//   data_out   signed Q8.8-scaled output sample, saturated
//   out_valid  data_out is valid
//   out_ready  downstream accepts data_out
// ---------------------------------------------------------------------------
module fir_interp2_folded #(
  parameter int ORDER              = 10,
  parameter int COEFFICIENTS_WIDTH = 16,
  parameter int DATA_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         out_valid,
  input  logic                         out_ready
);

  // Each polyphase branch sees ORDER/2+1 delayed samples at most.
  localparam int NUM_X     = ORDER / 2 + 1;
  localparam int IDX_W     = $clog2(NUM_X);
  localparam int PROD_W    = DATA_WIDTH + COEFFICIENTS_WIDTH;
  localparam int ACC_W     = PROD_W + 4;
  localparam int FRAC_BITS = 8;

  // The even branch uses all NUM_X samples. The odd branch uses one fewer.
  localparam logic [IDX_W-1:0] EVEN_LAST = IDX_W'(NUM_X - 1);
  localparam logic [IDX_W-1:0] ODD_LAST  = IDX_W'(NUM_X - 2);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((longint'(1) << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(longint'(1) << (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {
    IDLE,
    MAC_E,
    OUT_E,
    MAC_O,
    OUT_O
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [IDX_W-1:0]               tap_idx;
  logic signed [DATA_WIDTH-1:0]   x [NUM_X];
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        acc_shift;
  logic signed [COEFFICIENTS_WIDTH-1:0] coef_sel;
  logic signed [DATA_WIDTH-1:0]   x_sel;
  logic signed [PROD_W-1:0]       prod;
  logic signed [DATA_WIDTH-1:0]   sat_val;
  logic                           odd_phase;
  logic                           in_hs;
  logic                           out_hs;

  // Prototype taps h0..h10, indexed by the full prototype tap number.
  // The prototype is symmetric, so h[n] == h[10-n].
  function automatic logic signed [COEFFICIENTS_WIDTH-1:0] proto_coef(
    input logic [IDX_W:0] n
  );
    logic signed [COEFFICIENTS_WIDTH-1:0] c;
    c = '0;
    case (n)
      4'd0, 4'd10: c = COEFFICIENTS_WIDTH'(-293);
      4'd1, 4'd9:  c = COEFFICIENTS_WIDTH'(8);
      4'd2, 4'd8:  c = COEFFICIENTS_WIDTH'(21);
      4'd3, 4'd7:  c = COEFFICIENTS_WIDTH'(38);
      4'd4, 4'd6:  c = COEFFICIENTS_WIDTH'(51);
      4'd5:        c = COEFFICIENTS_WIDTH'(56);
      default:     c = '0;
    endcase
    return c;
  endfunction

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Prototype tap for branch entry k is h[2k] in the even phase and h[2k+1]
  // in the odd phase. That index is simply {k, phase}.
  assign odd_phase = (state == MAC_O);
  assign coef_sel  = proto_coef({tap_idx, odd_phase});
  assign x_sel     = x[tap_idx];
  assign prod      = PROD_W'(coef_sel) * PROD_W'(x_sel);

  // Drop the Q8.8 coefficient fraction with floor, then clamp to the
  // output range.
  assign acc_shift = acc >>> FRAC_BITS;

  always_comb begin
    sat_val = acc_shift[DATA_WIDTH-1:0];
    if (acc_shift > SAT_MAX) begin
      sat_val = DATA_WIDTH'(SAT_MAX);
    end else if (acc_shift < SAT_MIN) begin
      sat_val = DATA_WIDTH'(SAT_MIN);
    end
  end

  // State register. Reset returns to IDLE from anywhere, which abandons any
  // sample that is part-way through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and in_ready. An OUT state only moves on after
  // out_valid has been raised and the downstream accepts, so a stall just
  // holds the FSM in place.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = MAC_E;
        end
      end
      MAC_E: begin
        if (tap_idx == EVEN_LAST) begin
          state_next = OUT_E;
        end
      end
      OUT_E: begin
        if (out_hs) begin
          state_next = MAC_O;
        end
      end
      MAC_O: begin
        if (tap_idx == ODD_LAST) begin
          state_next = OUT_O;
        end
      end
      OUT_O: begin
        if (out_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: delay line, accumulator, tap counter and output register.
  // The delay line moves only on an input handshake. Samples offered while
  // the block is busy are never captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_X; k++) begin
        x[k] <= '0;
      end
      acc       <= '0;
      tap_idx   <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            x[0] <= data_in;
            for (int k = 1; k < NUM_X; k++) begin
              x[k] <= x[k-1];
            end
            acc     <= '0;
            tap_idx <= '0;
          end
        end
        MAC_E, MAC_O: begin
          acc     <= acc + ACC_W'(prod);
          tap_idx <= tap_idx + 1'b1;
        end
        OUT_E, OUT_O: begin
          // The first cycle in an OUT state publishes the result. Later
          // cycles wait for the downstream to accept it.
          if (!out_valid) begin
            data_out  <= sat_val;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            tap_idx   <= '0;
          end
        end
        default: begin
          acc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp2_folded.sv
// ---------------------------------------------------------------------------
// tb_fir_interp2_folded
//
// Directed testbench for fir_interp2_folded. It covers reset state, the
// impulse response, saturation on DC input, handshake timing, output
// backpressure, inputs offered while busy, and asynchronous reset part-way
// through a sample. Inputs are driven and outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_fir_interp2_folded;

  logic        clk;
  logic        reset_n;
  logic [15:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;
  int cyc;

  // Prototype impulse response, interleaved even/odd, followed by silence.
  localparam logic [15:0] EXP_IMP [24] = '{
    16'hFEDB, 16'h0008, 16'h0015, 16'h0026, 16'h0033, 16'h0038,
    16'h0033, 16'h0026, 16'h0015, 16'h0008, 16'hFEDB, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  logic [15:0] seq_got [24];
  bit          seq_to  [24];

  fir_interp2_folded dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so timing checks can work in cycles.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Offer one sample and wait, with a bound, until it is accepted.
  task automatic push(input logic [15:0] d, output bit to);
    int n;
    n        = 0;
    to       = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) to = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait, with a bound, for the next output and let it be accepted. With
  // busy set, in_valid and data_in are toggled randomly while the block
  // is not idle.
  task automatic collect(input bit busy, output logic [15:0] d, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    d  = '0;
    while (!out_valid && n < 64) begin
      if (busy) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = 16'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (!out_valid) to = 1'b1;
    else            d  = data_out;
    if (busy) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Feed 0x0100 followed by eleven zeros and record all 24 outputs.
  task automatic run_impulse(input bit busy);
    bit          t;
    logic [15:0] d;
    for (int i = 0; i < 12; i++) begin
      push((i == 0) ? 16'h0100 : 16'h0000, t);
      collect(busy, d, seq_to[2*i]);
      seq_got[2*i] = d;
      seq_to[2*i]  = seq_to[2*i] | t;
      collect(busy, d, seq_to[2*i+1]);
      seq_got[2*i+1] = d;
    end
  endtask

  // Push zeros through the delay line without checking the results.
  task automatic flush(input int count);
    bit          t;
    logic [15:0] d;
    for (int i = 0; i < count; i++) begin
      push(16'h0000, t);
      collect(1'b0, d, t);
      collect(1'b0, d, t);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
    end
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data_out got %h want 0000", data_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    out_ready = 1'b1;
    run_impulse(1'b0);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (seq_to[i] || seq_got[i] !== EXP_IMP[i]) begin
        errors++;
        $display("[TB] FAIL impulse[%0d] got %h (timeout %0b) want %h",
                 i, seq_got[i], seq_to[i], EXP_IMP[i]);
      end
    end
  endtask

  task automatic test_timing();
    int n, a, a2, rise_e, rise_o;
    out_ready = 1'b1;
    data_in   = 16'h0000;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    a = cyc + 1;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 64) begin @(negedge clk); n++; end
    rise_e = cyc;
    checks++;
    if (rise_e - a !== 7) begin
      errors++;
      $display("[TB] FAIL even_latency got %0d want 7", rise_e - a);
    end
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 64) begin @(negedge clk); n++; end
    rise_o = cyc;
    checks++;
    if (rise_o - a !== 14) begin
      errors++;
      $display("[TB] FAIL odd_latency got %0d want 14", rise_o - a);
    end
    n = 0;
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    a2 = cyc + 1;
    checks++;
    if (a2 - a !== 16) begin
      errors++;
      $display("[TB] FAIL input_period got %0d want 16", a2 - a);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL in_ready_pulse got %0b want 0", in_ready);
    end
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (cyc - a2 !== 15) begin
      errors++;
      $display("[TB] FAIL second_sample_done got %0d want 15", cyc - a2);
    end
  endtask

  task automatic test_backpressure();
    bit          t;
    int          n;
    logic [15:0] d;
    out_ready = 1'b0;
    push(16'h0100, t);
    n = 0;
    while (!out_valid && n < 64) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || data_out !== 16'hFEDB || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_even_hold[%0d] got v=%0b d=%h r=%0b want v=1 d=FEDB r=0",
                 i, out_valid, data_out, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_even_release got %0b want 0", out_valid);
    end
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 64) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || data_out !== 16'h0008 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_odd_hold[%0d] got v=%0b d=%h r=%0b want v=1 d=0008 r=0",
                 i, out_valid, data_out, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_odd_release got r=%0b v=%0b want r=1 v=0",
               in_ready, out_valid);
    end
    push(16'h0000, t);
    collect(1'b0, d, t);
    checks++;
    if (t || d !== 16'h0015) begin
      errors++;
      $display("[TB] FAIL bp_next_even got %h want 0015", d);
    end
    collect(1'b0, d, t);
    checks++;
    if (t || d !== 16'h0026) begin
      errors++;
      $display("[TB] FAIL bp_next_odd got %h want 0026", d);
    end
    flush(5);
  endtask

  task automatic test_busy_input();
    out_ready = 1'b1;
    run_impulse(1'b1);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (seq_to[i] || seq_got[i] !== EXP_IMP[i]) begin
        errors++;
        $display("[TB] FAIL busy[%0d] got %h (timeout %0b) want %h",
                 i, seq_got[i], seq_to[i], EXP_IMP[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit          t;
    logic [15:0] d;
    out_ready = 1'b1;
    push(16'h0100, t);
    collect(1'b0, d, t);
    collect(1'b0, d, t);
    checks++;
    if (t || d !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL arst_pre_odd got %h want 0008", d);
    end
    push(16'h0100, t);
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_busy got in_ready=%0b want 0", in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL arst_immediate got r=%0b v=%0b d=%h want r=1 v=0 d=0000",
               in_ready, out_valid, data_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_impulse(1'b0);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (seq_to[i] || seq_got[i] !== EXP_IMP[i]) begin
        errors++;
        $display("[TB] FAIL arst_impulse[%0d] got %h (timeout %0b) want %h",
                 i, seq_got[i], seq_to[i], EXP_IMP[i]);
      end
    end
  endtask

  task automatic test_saturation();
    bit          t, te, tod;
    logic [15:0] ye, yo;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(16'h7FFF, t);
      collect(1'b0, ye, te);
      collect(1'b0, yo, tod);
      if (i == 1) begin
        checks++;
        if (t || tod || yo !== 16'h03FF) begin
          errors++;
          $display("[TB] FAIL sat_odd_first got %h want 03FF", yo);
        end
      end
      if (i >= 6) begin
        checks++;
        if (t || te || ye !== 16'h8000) begin
          errors++;
          $display("[TB] FAIL sat_even[%0d] got %h want 8000", i, ye);
        end
      end
      if (i >= 5) begin
        checks++;
        if (t || tod || yo !== 16'h49FF) begin
          errors++;
          $display("[TB] FAIL sat_odd[%0d] got %h want 49FF", i, yo);
        end
      end
    end
  endtask

  // Absolute time limit so a stuck handshake still ends the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_impulse();
    test_timing();
    test_backpressure();
    test_busy_input();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
